// File: rtl/exec_csr_unit_pkg.sv
// Shared constants for the execute/CSR slice: ALU operation codes, branch
// condition codes and the CSR address map.
package exec_csr_unit_pkg;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_LUI    = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_funct3_e;

    localparam logic [11:0] CSR_USTATUS  = 12'h000;
    localparam logic [11:0] CSR_UIE      = 12'h004;
    localparam logic [11:0] CSR_UTVEC    = 12'h005;
    localparam logic [11:0] CSR_USCRATCH = 12'h040;
    localparam logic [11:0] CSR_UEPC     = 12'h041;
    localparam logic [11:0] CSR_UCAUSE   = 12'h042;
    localparam logic [11:0] CSR_UTVAL    = 12'h043;
    localparam logic [11:0] CSR_UIP      = 12'h044;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_TIME     = 12'hC01;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_TIMEH    = 12'hC81;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;

endpackage

// File: rtl/exec_csr_unit_if.sv
// CSR access bundle: generic and exception write requests, read/debug
// ports, direct register views and the external counters.
interface exec_csr_unit_if;
    logic        csr_write;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        ex_write;
    logic [31:0] ex_uepc;
    logic [31:0] ex_ucause;
    logic [31:0] ex_utval;
    logic [11:0] dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] utvec;
    logic [31:0] uepc;
    logic [31:0] ustatus;
    logic [31:0] utval;
    logic [63:0] cycles;
    logic [63:0] cnt_time;
    logic [63:0] instret;

    modport master (
        output csr_write, csr_addr, csr_wdata, ex_write, ex_uepc, ex_ucause,
               ex_utval, dbg_addr, cycles, cnt_time, instret,
        input  csr_rdata, dbg_data, utvec, uepc, ustatus, utval
    );

    modport slave (
        input  csr_write, csr_addr, csr_wdata, ex_write, ex_uepc, ex_ucause,
               ex_utval, dbg_addr, cycles, cnt_time, instret,
        output csr_rdata, dbg_data, utvec, uepc, ustatus, utval
    );
endinterface

// File: rtl/exec_csr_unit_csr_file.sv
// User-mode CSR register file with read-only counter views. Exception
// writes take priority over a generic write to the same register.
module csr_file
    import exec_csr_unit_pkg::*;
#(
    parameter logic [31:0] UTVEC_RST   = 32'h0000_0000,
    parameter logic [31:0] USTATUS_RST = 32'h0000_0001
) (
    input logic            iCLK,
    input logic            iRST,
    exec_csr_unit_if.slave bus
);

    logic [31:0] ustatus_q, uie_q, utvec_q, uscratch_q, uepc_q, ucause_q, utval_q, uip_q;
    logic [31:0] ustatus_d, uie_d, utvec_d, uscratch_d, uepc_d, ucause_d, utval_d, uip_d;

    // Combinational CSR decode shared by the main and debug read ports.
    function automatic logic [31:0] csr_read(input logic [11:0] addr);
        logic [31:0] val;
        case (addr)
            CSR_USTATUS:  val = ustatus_q;
            CSR_UIE:      val = uie_q;
            CSR_UTVEC:    val = utvec_q;
            CSR_USCRATCH: val = uscratch_q;
            CSR_UEPC:     val = uepc_q;
            CSR_UCAUSE:   val = ucause_q;
            CSR_UTVAL:    val = utval_q;
            CSR_UIP:      val = uip_q;
            CSR_CYCLE:    val = bus.cycles[31:0];
            CSR_TIME:     val = bus.cnt_time[31:0];
            CSR_INSTRET:  val = bus.instret[31:0];
            CSR_CYCLEH:   val = bus.cycles[63:32];
            CSR_TIMEH:    val = bus.cnt_time[63:32];
            CSR_INSTRETH: val = bus.instret[63:32];
            default:      val = 32'd0;
        endcase
        return val;
    endfunction

    // Next-state: generic write first, then exception write overrides.
    always_comb begin
        ustatus_d  = ustatus_q;
        uie_d      = uie_q;
        utvec_d    = utvec_q;
        uscratch_d = uscratch_q;
        uepc_d     = uepc_q;
        ucause_d   = ucause_q;
        utval_d    = utval_q;
        uip_d      = uip_q;
        if (bus.csr_write) begin
            case (bus.csr_addr)
                CSR_USTATUS:  ustatus_d  = bus.csr_wdata;
                CSR_UIE:      uie_d      = bus.csr_wdata;
                CSR_UTVEC:    utvec_d    = bus.csr_wdata;
                CSR_USCRATCH: uscratch_d = bus.csr_wdata;
                CSR_UEPC:     uepc_d     = bus.csr_wdata;
                CSR_UCAUSE:   ucause_d   = bus.csr_wdata;
                CSR_UTVAL:    utval_d    = bus.csr_wdata;
                CSR_UIP:      uip_d      = bus.csr_wdata;
                default:      ustatus_d  = ustatus_q;
            endcase
        end else begin
            ustatus_d = ustatus_q;
        end
        if (bus.ex_write) begin
            uepc_d   = bus.ex_uepc;
            ucause_d = bus.ex_ucause;
            utval_d  = bus.ex_utval;
        end else begin
            uepc_d = uepc_d;
        end
    end

    // Register update; reset wins over any write on the same edge.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            ustatus_q  <= USTATUS_RST;
            uie_q      <= 32'd0;
            utvec_q    <= UTVEC_RST;
            uscratch_q <= 32'd0;
            uepc_q     <= 32'd0;
            ucause_q   <= 32'd0;
            utval_q    <= 32'd0;
            uip_q      <= 32'd0;
        end else begin
            ustatus_q  <= ustatus_d;
            uie_q      <= uie_d;
            utvec_q    <= utvec_d;
            uscratch_q <= uscratch_d;
            uepc_q     <= uepc_d;
            ucause_q   <= ucause_d;
            utval_q    <= utval_d;
            uip_q      <= uip_d;
        end
    end

    // Read ports return the value held before any write on this cycle.
    always_comb begin
        bus.csr_rdata = csr_read(bus.csr_addr);
        bus.dbg_data  = csr_read(bus.dbg_addr);
    end

    assign bus.utvec   = utvec_q;
    assign bus.uepc    = uepc_q;
    assign bus.ustatus = ustatus_q;
    assign bus.utval   = utval_q;

endmodule

// File: rtl/exec_csr_unit.sv
// Execute stage: combinational ALU and branch compare, plus the user CSR file.
module exec_csr_unit
    import exec_csr_unit_pkg::*;
#(
    parameter logic [31:0] UTVEC_RST   = 32'h0000_0000,
    parameter logic [31:0] USTATUS_RST = 32'h0000_0001
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [4:0]  iALUControl,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    output logic [31:0] oResult,
    output logic        oZero,
    input  logic [2:0]  iFunct3,
    input  logic [31:0] iBrA,
    input  logic [31:0] iBrB,
    output logic        oBranch,
    input  logic        iCSRWrite,
    input  logic [11:0] iCSRAddr,
    input  logic [31:0] iCSRWData,
    output logic [31:0] oCSRRData,
    input  logic        iExWrite,
    input  logic [31:0] iExUEPC,
    input  logic [31:0] iExUCAUSE,
    input  logic [31:0] iExUTVAL,
    output logic [31:0] oUTVEC,
    output logic [31:0] oUEPC,
    output logic [31:0] oUSTATUS,
    output logic [31:0] oUTVAL,
    input  logic [63:0] iCycles,
    input  logic [63:0] iTime,
    input  logic [63:0] iInstret,
    input  logic [11:0] iDbgAddr,
    output logic [31:0] oDbgData
);

    logic [63:0] prod_ss, prod_su, prod_uu;
    logic [31:0] alu_res;
    logic        br_taken;
    logic        div_ovf;

    // Full 64-bit products; low/high halves are picked per operation.
    assign prod_ss = $signed({{32{iA[31]}}, iA}) * $signed({{32{iB[31]}}, iB});
    assign prod_su = $signed({{32{iA[31]}}, iA}) * $signed({32'd0, iB});
    assign prod_uu = {32'd0, iA} * {32'd0, iB};
    assign div_ovf = (iA == 32'h8000_0000) && (iB == 32'hFFFF_FFFF);

    // ALU operation select; division corner cases are handled explicitly.
    always_comb begin
        alu_res = 32'd0;
        case (iALUControl)
            ALU_ADD:    alu_res = iA + iB;
            ALU_SUB:    alu_res = iA - iB;
            ALU_AND:    alu_res = iA & iB;
            ALU_OR:     alu_res = iA | iB;
            ALU_XOR:    alu_res = iA ^ iB;
            ALU_SLL:    alu_res = iA << iB[4:0];
            ALU_SRL:    alu_res = iA >> iB[4:0];
            ALU_SRA:    alu_res = $unsigned($signed(iA) >>> iB[4:0]);
            ALU_SLT:    alu_res = {31'd0, $signed(iA) < $signed(iB)};
            ALU_SLTU:   alu_res = {31'd0, iA < iB};
            ALU_LUI:    alu_res = iB;
            ALU_MUL:    alu_res = prod_uu[31:0];
            ALU_MULH:   alu_res = prod_ss[63:32];
            ALU_MULHSU: alu_res = prod_su[63:32];
            ALU_MULHU:  alu_res = prod_uu[63:32];
            ALU_DIV: begin
                if (iB == 32'd0)  alu_res = 32'hFFFF_FFFF;
                else if (div_ovf) alu_res = 32'h8000_0000;
                else              alu_res = $unsigned($signed(iA) / $signed(iB));
            end
            ALU_DIVU: begin
                if (iB == 32'd0) alu_res = 32'hFFFF_FFFF;
                else             alu_res = iA / iB;
            end
            ALU_REM: begin
                if (iB == 32'd0)  alu_res = iA;
                else if (div_ovf) alu_res = 32'd0;
                else              alu_res = $unsigned($signed(iA) % $signed(iB));
            end
            ALU_REMU: begin
                if (iB == 32'd0) alu_res = iA;
                else             alu_res = iA % iB;
            end
            default:    alu_res = 32'd0;
        endcase
    end

    assign oResult = alu_res;
    assign oZero   = (alu_res == 32'd0);

    // Branch condition evaluation; reserved funct3 codes never branch.
    always_comb begin
        br_taken = 1'b0;
        case (iFunct3)
            BR_EQ:   br_taken = (iBrA == iBrB);
            BR_NE:   br_taken = (iBrA != iBrB);
            BR_LT:   br_taken = ($signed(iBrA) <  $signed(iBrB));
            BR_GE:   br_taken = ($signed(iBrA) >= $signed(iBrB));
            BR_LTU:  br_taken = (iBrA <  iBrB);
            BR_GEU:  br_taken = (iBrA >= iBrB);
            default: br_taken = 1'b0;
        endcase
    end

    assign oBranch = br_taken;

    exec_csr_unit_if csr_bus ();

    assign csr_bus.csr_write = iCSRWrite;
    assign csr_bus.csr_addr  = iCSRAddr;
    assign csr_bus.csr_wdata = iCSRWData;
    assign csr_bus.ex_write  = iExWrite;
    assign csr_bus.ex_uepc   = iExUEPC;
    assign csr_bus.ex_ucause = iExUCAUSE;
    assign csr_bus.ex_utval  = iExUTVAL;
    assign csr_bus.dbg_addr  = iDbgAddr;
    assign csr_bus.cycles    = iCycles;
    assign csr_bus.cnt_time  = iTime;
    assign csr_bus.instret   = iInstret;

    csr_file #(
        .UTVEC_RST   (UTVEC_RST),
        .USTATUS_RST (USTATUS_RST)
    ) u_csr_file (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (csr_bus)
    );

    assign oCSRRData = csr_bus.csr_rdata;
    assign oDbgData  = csr_bus.dbg_data;
    assign oUTVEC    = csr_bus.utvec;
    assign oUEPC     = csr_bus.uepc;
    assign oUSTATUS  = csr_bus.ustatus;
    assign oUTVAL    = csr_bus.utval;

endmodule

// File: tb/tb_exec_csr_unit.sv
// Self-checking bench for exec_csr_unit: directed corner cases plus random
// stimulus against an arithmetic reference model.
module tb_exec_csr_unit;

    localparam logic [31:0] P_UTVEC   = 32'h1000_0100;
    localparam logic [31:0] P_USTATUS = 32'h0000_0001;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [4:0]  alu_op;
    logic [31:0] a, b, result;
    logic        zero;
    logic [2:0]  funct3;
    logic [31:0] br_a, br_b;
    logic        branch;

    exec_csr_unit_if bus ();

    exec_csr_unit #(.UTVEC_RST(P_UTVEC), .USTATUS_RST(P_USTATUS)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iALUControl(alu_op), .iA(a), .iB(b), .oResult(result), .oZero(zero),
        .iFunct3(funct3), .iBrA(br_a), .iBrB(br_b), .oBranch(branch),
        .iCSRWrite(bus.csr_write), .iCSRAddr(bus.csr_addr), .iCSRWData(bus.csr_wdata),
        .oCSRRData(bus.csr_rdata),
        .iExWrite(bus.ex_write), .iExUEPC(bus.ex_uepc), .iExUCAUSE(bus.ex_ucause),
        .iExUTVAL(bus.ex_utval),
        .oUTVEC(bus.utvec), .oUEPC(bus.uepc), .oUSTATUS(bus.ustatus), .oUTVAL(bus.utval),
        .iCycles(bus.cycles), .iTime(bus.cnt_time), .iInstret(bus.instret),
        .iDbgAddr(bus.dbg_addr), .oDbgData(bus.dbg_data)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: index 0 ustatus,1 uie,2 utvec,3 uscratch,4 uepc,5 ucause,6 utval,7 uip
    logic [31:0] m [8];
    logic [11:0] map_addr [8] = '{12'h000, 12'h004, 12'h005, 12'h040,
                                  12'h041, 12'h042, 12'h043, 12'h044};
    logic [11:0] ctr_addr [6] = '{12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82};

    function automatic int m_idx(input logic [11:0] addr);
        for (int i = 0; i < 8; i++) if (map_addr[i] == addr) return i;
        return -1;
    endfunction

    function automatic logic [31:0] ref_read(input logic [11:0] addr);
        logic [63:0] c, t, n;
        c = bus.cycles; t = bus.cnt_time; n = bus.instret;
        if (m_idx(addr) >= 0) return m[m_idx(addr)];
        case (addr)
            12'hC00: return c[31:0];
            12'hC01: return t[31:0];
            12'hC02: return n[31:0];
            12'hC80: return c[63:32];
            12'hC81: return t[63:32];
            12'hC82: return n[63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i] = 32'd0;
        m[0] = P_USTATUS;
        m[2] = P_UTVEC;
    endtask

    // Applies the rising-edge effect of the current inputs to the model.
    task automatic model_edge();
        if (!iRST) model_reset();
        else begin
            if (bus.csr_write && m_idx(bus.csr_addr) >= 0) m[m_idx(bus.csr_addr)] = bus.csr_wdata;
            if (bus.ex_write) begin
                m[4] = bus.ex_uepc; m[5] = bus.ex_ucause; m[6] = bus.ex_utval;
            end
        end
    endtask

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        longint unsigned ux, uy;
        logic [63:0] p;
        logic [4:0] sh5;
        int sh;
        sx = longint'($signed(x)); sy = longint'($signed(y));
        ux = {32'd0, x};           uy = {32'd0, y};
        sh5 = y[4:0]; sh = int'(sh5);
        case (op)
            0: p = ux + uy;
            1: p = ux - uy;
            2: p = ux & uy;
            3: p = ux | uy;
            4: p = ux ^ uy;
            5: p = ux << sh;
            6: p = ux >> sh;
            7: p = sx >>> sh;
            8: p = (sx < sy) ? 64'd1 : 64'd0;
            9: p = (ux < uy) ? 64'd1 : 64'd0;
            10: p = uy;
            11: p = sx * sy;
            12: p = (sx * sy) >>> 32;
            13: p = (sx * longint'(uy)) >>> 32;
            14: p = (ux * uy) >> 32;
            15: if (y == 32'd0) p = 64'hFFFF_FFFF; else p = sx / sy;
            16: if (y == 32'd0) p = 64'hFFFF_FFFF; else p = ux / uy;
            17: if (y == 32'd0) p = ux; else p = sx % sy;
            18: if (y == 32'd0) p = ux; else p = ux % uy;
            default: p = 64'd0;
        endcase
        return p[31:0];
    endfunction

    function automatic logic ref_br(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        sx = longint'($signed(x)); sy = longint'($signed(y));
        case (f)
            3'b000: return x == y;
            3'b001: return x != y;
            3'b100: return sx < sy;
            3'b101: return sx >= sy;
            3'b110: return x < y;
            3'b111: return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic idle_csr();
        bus.csr_write = 1'b0; bus.csr_addr = 12'h000; bus.csr_wdata = 32'd0;
        bus.ex_write = 1'b0; bus.ex_uepc = 32'd0; bus.ex_ucause = 32'd0; bus.ex_utval = 32'd0;
        bus.dbg_addr = 12'h000;
        bus.cycles = 64'd0; bus.cnt_time = 64'd0; bus.instret = 64'd0;
    endtask

    task automatic test_reset();
        idle_csr();
        iRST = 1'b0;
        bus.csr_write = 1'b1; bus.csr_addr = 12'h005; bus.csr_wdata = 32'hDEAD_BEEF;
        bus.ex_write = 1'b1; bus.ex_uepc = 32'h1111_1111;
        step();
        model_reset();
        step();
        idle_csr();
        iRST = 1'b1;
        #1;
        n_checks++;
        if (bus.utvec !== P_UTVEC) $display("FAIL reset_utvec got %h want %h", bus.utvec, P_UTVEC);
        else n_pass++;
        n_checks++;
        if (bus.ustatus !== P_USTATUS) $display("FAIL reset_ustatus got %h want %h", bus.ustatus, P_USTATUS);
        else n_pass++;
        n_checks++;
        if (bus.uepc !== 32'd0 || bus.utval !== 32'd0)
            $display("FAIL reset_uepc_utval got %h/%h want 0/0", bus.uepc, bus.utval);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            bus.csr_addr = map_addr[i];
            #1;
            n_checks++;
            if (bus.csr_rdata !== ref_read(map_addr[i]))
                $display("FAIL reset_read addr %h got %h want %h", map_addr[i], bus.csr_rdata, ref_read(map_addr[i]));
            else n_pass++;
        end
    endtask

    task automatic test_alu_directed();
        logic [4:0]  ops  [6] = '{5'd0, 5'd7, 5'd14, 5'd15, 5'd17, 5'd15};
        logic [31:0] as   [6] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs   [6] = '{32'd1, 32'd4, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exps [6] = '{32'd0, 32'hF800_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
        for (int i = 0; i < 6; i++) begin
            alu_op = ops[i]; a = as[i]; b = bs[i];
            #1;
            n_checks++;
            if (result !== exps[i]) $display("FAIL alu_dir op %0d got %h want %h", ops[i], result, exps[i]);
            else n_pass++;
        end
        alu_op = 5'd0; a = 32'hFFFF_FFFF; b = 32'd1;
        #1;
        n_checks++;
        if (zero !== 1'b1) $display("FAIL alu_zero got %b want 1", zero);
        else n_pass++;
        alu_op = 5'd17; a = 32'd9; b = 32'd0;
        #1;
        n_checks++;
        if (result !== 32'd9) $display("FAIL alu_rem_by_zero got %h want 00000009", result);
        else n_pass++;
    endtask

    task automatic test_alu_random();
        logic [31:0] exp;
        for (int i = 0; i < 400; i++) begin
            alu_op = 5'($urandom_range(0, 31));
            a = rnd_operand(); b = rnd_operand();
            #1;
            exp = ref_alu(int'(alu_op), a, b);
            n_checks++;
            if (result !== exp || zero !== (exp == 32'd0))
                $display("FAIL alu_rand op %0d a %h b %h got %h/%b want %h/%b",
                         alu_op, a, b, result, zero, exp, exp == 32'd0);
            else n_pass++;
        end
    endtask

    task automatic test_branch();
        logic [2:0] fs [3] = '{3'b100, 3'b110, 3'b010};
        logic       es [3] = '{1'b1, 1'b0, 1'b0};
        logic       exp;
        for (int i = 0; i < 3; i++) begin
            funct3 = fs[i]; br_a = 32'hFFFF_FFFF; br_b = 32'd1;
            #1;
            n_checks++;
            if (branch !== es[i]) $display("FAIL br_dir f3 %b got %b want %b", fs[i], branch, es[i]);
            else n_pass++;
        end
        for (int i = 0; i < 200; i++) begin
            funct3 = 3'($urandom_range(0, 7));
            br_a = rnd_operand();
            br_b = ($urandom_range(0, 3) == 0) ? br_a : rnd_operand();
            #1;
            exp = ref_br(funct3, br_a, br_b);
            n_checks++;
            if (branch !== exp) $display("FAIL br_rand f3 %b a %h b %h got %b want %b", funct3, br_a, br_b, branch, exp);
            else n_pass++;
        end
    endtask

    task automatic test_csr_directed();
        idle_csr();
        bus.csr_write = 1'b1; bus.csr_addr = 12'h040; bus.csr_wdata = 32'h1234_5678;
        #1;
        n_checks++;
        if (bus.csr_rdata !== m[3]) $display("FAIL csr_read_old got %h want %h", bus.csr_rdata, m[3]);
        else n_pass++;
        model_edge();
        step();
        bus.csr_write = 1'b0;
        #1;
        n_checks++;
        if (bus.csr_rdata !== 32'h1234_5678) $display("FAIL csr_uscratch got %h want 12345678", bus.csr_rdata);
        else n_pass++;
        bus.cycles = 64'h0000_0001_0000_0002;
        bus.csr_write = 1'b1; bus.csr_addr = 12'hC00; bus.csr_wdata = 32'hFFFF_FFFF;
        bus.dbg_addr = 12'hC80;
        model_edge();
        step();
        bus.csr_write = 1'b0;
        #1;
        n_checks++;
        if (bus.csr_rdata !== 32'd2) $display("FAIL csr_cycle got %h want 00000002", bus.csr_rdata);
        else n_pass++;
        n_checks++;
        if (bus.dbg_data !== 32'd1) $display("FAIL dbg_cycleh got %h want 00000001", bus.dbg_data);
        else n_pass++;
        bus.csr_write = 1'b1; bus.csr_addr = 12'h123; bus.csr_wdata = 32'hCAFE_0000;
        model_edge();
        step();
        bus.csr_write = 1'b0;
        #1;
        n_checks++;
        if (bus.csr_rdata !== 32'd0) $display("FAIL csr_unmapped got %h want 00000000", bus.csr_rdata);
        else n_pass++;
    endtask

    task automatic test_csr_random();
        logic [11:0] pick [2];
        int k;
        for (int i = 0; i < 300; i++) begin
            for (int j = 0; j < 2; j++) begin
                k = $urandom_range(0, 15);
                if (k < 8)       pick[j] = map_addr[k];
                else if (k < 14) pick[j] = ctr_addr[k - 8];
                else             pick[j] = 12'($urandom);
            end
            bus.csr_addr = pick[0]; bus.dbg_addr = pick[1];
            bus.csr_write = 1'($urandom); bus.csr_wdata = $urandom;
            bus.ex_write = ($urandom_range(0, 3) == 0);
            bus.ex_uepc = $urandom; bus.ex_ucause = $urandom; bus.ex_utval = $urandom;
            bus.cycles = {$urandom, $urandom}; bus.cnt_time = {$urandom, $urandom};
            bus.instret = {$urandom, $urandom};
            #1;
            n_checks++;
            if (bus.csr_rdata !== ref_read(pick[0]) || bus.dbg_data !== ref_read(pick[1]))
                $display("FAIL csr_rand_read addr %h/%h got %h/%h want %h/%h", pick[0], pick[1],
                         bus.csr_rdata, bus.dbg_data, ref_read(pick[0]), ref_read(pick[1]));
            else n_pass++;
            model_edge();
            step();
            n_checks++;
            if (bus.utvec !== m[2] || bus.uepc !== m[4] || bus.ustatus !== m[0] || bus.utval !== m[6])
                $display("FAIL csr_rand_views got %h %h %h %h want %h %h %h %h", bus.utvec, bus.uepc,
                         bus.ustatus, bus.utval, m[2], m[4], m[0], m[6]);
            else n_pass++;
        end
        idle_csr();
    endtask

    task automatic test_exception();
        idle_csr();
        bus.csr_write = 1'b1; bus.csr_addr = 12'h041; bus.csr_wdata = 32'hAAAA_AAAA;
        bus.ex_write = 1'b1; bus.ex_uepc = 32'h5555_0000;
        bus.ex_ucause = 32'h0000_000B; bus.ex_utval = 32'h0BAD_F00D;
        step();
        idle_csr();
        bus.csr_addr = 12'h042;
        #1;
        n_checks++;
        if (bus.uepc !== 32'h5555_0000) $display("FAIL ex_uepc_priority got %h want 55550000", bus.uepc);
        else n_pass++;
        n_checks++;
        if (bus.csr_rdata !== 32'h0000_000B || bus.utval !== 32'h0BAD_F00D)
            $display("FAIL ex_cause_tval got %h/%h want 0000000b/0badf00d", bus.csr_rdata, bus.utval);
        else n_pass++;
        iRST = 1'b0;
        step();
        iRST = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (bus.utvec !== P_UTVEC || bus.uepc !== 32'd0)
            $display("FAIL ex_then_reset got %h/%h want %h/00000000", bus.utvec, bus.uepc, P_UTVEC);
        else n_pass++;
    endtask

    initial begin
        iRST = 1'b0;
        alu_op = 5'd0; a = 32'd0; b = 32'd0;
        funct3 = 3'b000; br_a = 32'd0; br_b = 32'd0;
        idle_csr();
        model_reset();
        #1;
        test_reset();
        test_alu_directed();
        test_alu_random();
        test_branch();
        test_csr_directed();
        test_csr_random();
        test_exception();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
